// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, keeps one fetch in flight, buffers one instruction for decode.
// Optional FETCH_CTRL_PERF_EN adds fetch/drop counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] drop_cnt_o,
`endif
  input  logic        inst_ready_i
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        drop;
  logic        grant;
  logic        load;
  logic        discard;
  logic [31:0] target;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc_i[1:0];
  assign target      = {redirect_pc_i[31:2], 2'b00};
  assign imem_addr_o = pc;
  assign imem_req_o  = (state == REQ) && (!inst_valid_o || inst_ready_i);
  assign grant       = imem_req_o && imem_gnt_i;
  // A response arriving together with a redirect is stale as well.
  assign load        = (state == WAIT) && imem_rvalid_i && !drop && !redirect_i;
  assign discard     = (state == WAIT) && imem_rvalid_i && (drop || redirect_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      drop         <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o       <= 32'h0;
      inst_pc_o    <= 32'h0;
    end else begin
      if (inst_valid_o && inst_ready_i) inst_valid_o <= 1'b0;
      if (load) begin
        inst_o       <= imem_rdata_i;
        inst_pc_o    <= req_pc;
        inst_valid_o <= 1'b1;
      end
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (grant) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
          if (redirect_i) begin
            pc           <= target;
            inst_valid_o <= 1'b0;
            if (grant) drop <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state <= REQ;
            drop  <= 1'b0;
          end
          if (redirect_i) begin
            pc           <= target;
            inst_valid_o <= 1'b0;
            if (!imem_rvalid_i) drop <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_o <= 32'h0;
      drop_cnt_o  <= 32'h0;
    end else begin
      if (load)    fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (discard) drop_cnt_o  <= drop_cnt_o + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule
